spi_slave_byte: RTL and testbench

- SPI mode-0 slave (CPOL=0, CPHA=0), MSB-first. It terminates the SPI bus driven by the Nios II SPI master (spi_0 SCLK/SS_n/MOSI/MISO).
- The SPI pins are oversampled on the system clock. Each received word is presented on a valid/ready stream.
- Transmit words are taken from a one-deep buffer loaded over a valid/ready handshake.
- It is the device-side stage that consumes what the processor's SPI master produces and returns MISO data to it.

---
 rtl/spi_slave_pkg.sv | 24 ++
 rtl/spi_sync_edge.sv | 39 +++
 rtl/spi_slave_byte.sv | 209 ++++++++++++++++++++
 tb/tb_spi_slave_byte.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_pkg
//  Purpose  : Shared types and constants for the SPI mode-0 byte slave.
//  Revision : 1.0  initial release
// ============================================================================
package spi_slave_pkg;

    // Frame state: waiting for select, or shifting words.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Default SPI word width.
    localparam int c_DEF_DATA_W = 8;

    // Bit counter must hold 0..data_w inclusive.
    function automatic int bit_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : spi_sync_edge
//  Purpose  : Multi-flop synchronizer for one asynchronous pin, followed by
//             a single history flop for rise/fall detection.
//  Revision : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchronizer chain plus edge-history flop, reset to the pin's idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_byte.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_byte
//  Purpose  : Oversampled SPI mode-0 (CPOL=0, CPHA=0) MSB-first slave with a
//             valid/ready receive stream and a one-deep transmit buffer.
//  Revision : 1.0  initial release
// ============================================================================
module spi_slave_byte
    import spi_slave_pkg::*;
#(
    parameter int                DATA_W      = c_DEF_DATA_W,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL   = {DATA_W{1'b1}}
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              spi_sclk,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              rx_overrun,
    output logic              tx_underrun,
    output logic              frame_abort
);

    localparam int                c_CNT_W    = bit_cnt_w(DATA_W);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DATA_W);

    // Synchronized pin views
    logic w_sclk_level_unused, w_sclk_rise, w_sclk_fall;
    logic w_ss_level, w_ss_rise, w_ss_fall;
    logic w_mosi_s, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .i_async (spi_sclk),
        .o_level (w_sclk_level_unused),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .i_async (spi_ss_n),
        .o_level (w_ss_level),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .i_async (spi_mosi),
        .o_level (w_mosi_s),
        .o_rise  (w_mosi_rise_unused),
        .o_fall  (w_mosi_fall_unused)
    );

    // State and datapath registers
    state_t              r_state;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0]   r_rx_shift;
    logic [DATA_W-1:0]   r_tx_shift;
    logic [DATA_W-1:0]   r_tx_buf;
    logic                r_tx_full;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_rx_valid;
    logic                r_rx_overrun;
    logic                r_tx_underrun;
    logic                r_frame_abort;
    logic                r_word_done;
    logic [SYNC_STAGES:0] r_init;
    logic                r_ss_armed;

    // Control decodes
    logic              w_active;
    logic              w_start;
    logic              w_complete;
    logic              w_end;
    logic              w_reload;
    logic              w_load;
    logic              w_tx_write;
    logic [DATA_W-1:0] w_load_word;

    assign w_active    = (r_state == ST_ACTIVE);
    assign w_start     = (r_state == ST_IDLE) & w_ss_fall & r_ss_armed;
    assign w_complete  = w_active & (r_bit_cnt == c_CNT_FULL);
    assign w_end       = w_active & w_ss_rise;
    assign w_reload    = w_active & ~w_end & w_sclk_fall & r_word_done;
    assign w_load      = w_start | w_reload;
    assign w_tx_write  = tx_valid & ~r_tx_full;
    assign w_load_word = r_tx_full ? r_tx_buf : IDLE_FILL;

    // After reset the SS_n chain starts at its idle value, so a select that was
    // already low would look like a fresh falling edge. A frame is only accepted
    // once the flushed chain has shown SS_n high.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_init     <= '0;
            r_ss_armed <= 1'b0;
        end else begin
            r_init <= {r_init[SYNC_STAGES-1:0], 1'b1};
            if (r_init[SYNC_STAGES] && w_ss_level)
                r_ss_armed <= 1'b1;
        end
    end

    // One-deep TX buffer; a load in the same cycle sees the pre-write state.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_tx_buf  <= '0;
            r_tx_full <= 1'b0;
        end else if (w_load && r_tx_full) begin
            r_tx_full <= 1'b0;
        end else if (w_tx_write) begin
            r_tx_buf  <= tx_data;
            r_tx_full <= 1'b1;
        end
    end

    // Frame FSM, shift registers, RX stream and status pulses.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_rx_shift    <= '0;
            r_tx_shift    <= '0;
            r_word_done   <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_rx_overrun  <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_abort <= 1'b0;
        end else begin
            r_tx_underrun <= w_load & ~r_tx_full;
            r_rx_overrun  <= w_complete & r_rx_valid & ~rx_ready;
            r_frame_abort <= w_end & (r_bit_cnt != '0) & ~w_complete;

            // Deliver a finished word unless the previous one is still held.
            if (w_complete) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data  <= r_rx_shift;
                    r_rx_valid <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state     <= ST_ACTIVE;
                        r_bit_cnt   <= '0;
                        r_rx_shift  <= '0;
                        r_word_done <= 1'b0;
                        r_tx_shift  <= w_load_word;
                    end
                end
                ST_ACTIVE: begin
                    if (w_complete) begin
                        r_bit_cnt   <= '0;
                        r_word_done <= 1'b1;
                    end else if (w_sclk_rise && !w_end) begin
                        r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_mosi_s};
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                    end

                    if (w_end) begin
                        r_state     <= ST_IDLE;
                        r_bit_cnt   <= '0;
                        r_word_done <= 1'b0;
                    end else if (w_sclk_fall) begin
                        // The fall closing a word fetches the next one so
                        // multi-word frames run back to back.
                        if (r_word_done) begin
                            r_tx_shift  <= w_load_word;
                            r_word_done <= 1'b0;
                        end else begin
                            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign spi_miso    = w_active ? r_tx_shift[DATA_W-1] : 1'b1;
    assign spi_miso_oe = w_active;
    assign busy        = w_active;
    assign tx_ready    = ~r_tx_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign rx_overrun  = r_rx_overrun;
    assign tx_underrun = r_tx_underrun;
    assign frame_abort = r_frame_abort;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_byte.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave_byte
//  Purpose  : Directed self-checking bench for spi_slave_byte, acting as a
//             mode-0 SPI master with SCLK = CLOCK_50/8.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave_byte;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N  = 1'b0;
    logic       spi_sclk = 1'b0;
    logic       spi_ss_n = 1'b1;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       rx_overrun;
    logic       tx_underrun;
    logic       frame_abort;

    int n_cmp  = 0;
    int n_fail = 0;

    // Event counters maintained by the monitor
    int         n_under = 0;
    int         n_over  = 0;
    int         n_abort = 0;
    int         rx_cnt  = 0;
    logic [7:0] rx_log [16];

    always #10 CLOCK_50 = ~CLOCK_50;

    spi_slave_byte dut (
        .CLOCK_50    (CLOCK_50),
        .RESET_N     (RESET_N),
        .spi_sclk    (spi_sclk),
        .spi_ss_n    (spi_ss_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .rx_overrun  (rx_overrun),
        .tx_underrun (tx_underrun),
        .frame_abort (frame_abort)
    );

    // Count status pulses and log every accepted RX word
    always @(posedge CLOCK_50) begin
        if (tx_underrun) n_under <= n_under + 1;
        if (rx_overrun)  n_over  <= n_over + 1;
        if (frame_abort) n_abort <= n_abort + 1;
        if (rx_valid && rx_ready) begin
            rx_log[rx_cnt % 16] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
    end

    task automatic tx_write(input logic [7:0] d);
        @(negedge CLOCK_50);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
    endtask

    task automatic consume();
        @(negedge CLOCK_50);
        rx_ready = 1'b1;
        @(negedge CLOCK_50);
        rx_ready = 1'b0;
    endtask

    task automatic select();
        @(negedge CLOCK_50);
        spi_ss_n = 1'b0;
    endtask

    task automatic deselect();
        repeat (4) @(negedge CLOCK_50);
        spi_ss_n = 1'b1;
        repeat (8) @(negedge CLOCK_50);
    endtask

    // Shift nbits of one word. On the last word of a frame SS_n is raised
    // while SCLK is still high, so the closing fall never fetches a word.
    // rdy_pulse raises rx_ready only in the completion cycle of the word;
    // do_tx writes tx_w into the TX buffer mid-word.
    task automatic spi_word(input logic [7:0] w, input int nbits, input bit last,
                            input bit rdy_pulse, input bit do_tx,
                            input logic [7:0] tx_w, output logic [7:0] miso_w);
        miso_w = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_mosi = w[i];
            for (int j = 1; j <= 4; j++) begin
                @(negedge CLOCK_50);
                if (do_tx && i == 4 && j == 1) begin
                    tx_data  = tx_w;
                    tx_valid = 1'b1;
                end
                if (do_tx && i == 4 && j == 2) tx_valid = 1'b0;
            end
            miso_w[i] = spi_miso;
            spi_sclk = 1'b1;
            for (int j = 1; j <= 4; j++) begin
                @(negedge CLOCK_50);
                if (rdy_pulse && i == 0 && j == 3) rx_ready = 1'b1;
                if (rdy_pulse && i == 0 && j == 4) rx_ready = 1'b0;
            end
            if (last && i == 0) begin
                spi_ss_n = 1'b1;
                repeat (4) @(negedge CLOCK_50);
            end
            spi_sclk = 1'b0;
        end
        if (last) repeat (8) @(negedge CLOCK_50);
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        n_cmp++; if (spi_miso !== 1'b1) begin n_fail++; $display("FAIL reset_miso: got %b want 1", spi_miso); end
        n_cmp++; if (spi_miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe: got %b want 0", spi_miso_oe); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if ({rx_overrun, tx_underrun, frame_abort} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b want 000", {rx_overrun, tx_underrun, frame_abort}); end
        RESET_N = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [7:0] m;
        int u0;
        u0 = n_under;
        tx_write(8'hA5);
        n_cmp++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL basic_tx_full: got %b want 0", tx_ready); end
        select();
        repeat (5) @(negedge CLOCK_50);
        n_cmp++; if (busy !== 1'b1 || spi_miso_oe !== 1'b1) begin n_fail++; $display("FAIL basic_busy_oe: got %b%b want 11", busy, spi_miso_oe); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL basic_tx_ready_after_load: got %b want 1", tx_ready); end
        spi_word(8'h3C, 8, 1'b1, 1'b0, 1'b0, 8'h00, m);
        n_cmp++; if (m !== 8'hA5) begin n_fail++; $display("FAIL basic_miso: got %h want a5", m); end
        n_cmp++; if (rx_data !== 8'h3C || rx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rx: got %h/%b want 3c/1", rx_data, rx_valid); end
        n_cmp++; if (n_under - u0 !== 0) begin n_fail++; $display("FAIL basic_underrun: got %0d want 0", n_under - u0); end
        n_cmp++; if (busy !== 1'b0 || spi_miso !== 1'b1) begin n_fail++; $display("FAIL basic_idle_after: got busy %b miso %b want 0 1", busy, spi_miso); end
        consume();
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consume: got %b want 0", rx_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m0, m1;
        int u0, o0, a0, c0;
        u0 = n_under; o0 = n_over; a0 = n_abort; c0 = rx_cnt;
        tx_write(8'hC3);
        rx_ready = 1'b1;
        select();
        spi_word(8'h12, 8, 1'b0, 1'b0, 1'b1, 8'h5A, m0);
        spi_word(8'h34, 8, 1'b1, 1'b0, 1'b0, 8'h00, m1);
        n_cmp++; if (m0 !== 8'hC3) begin n_fail++; $display("FAIL b2b_miso0: got %h want c3", m0); end
        n_cmp++; if (m1 !== 8'h5A) begin n_fail++; $display("FAIL b2b_miso1: got %h want 5a", m1); end
        n_cmp++; if (rx_cnt - c0 !== 2) begin n_fail++; $display("FAIL b2b_rx_count: got %0d want 2", rx_cnt - c0); end
        n_cmp++; if (rx_log[c0 % 16] !== 8'h12) begin n_fail++; $display("FAIL b2b_rx0: got %h want 12", rx_log[c0 % 16]); end
        n_cmp++; if (rx_log[(c0 + 1) % 16] !== 8'h34) begin n_fail++; $display("FAIL b2b_rx1: got %h want 34", rx_log[(c0 + 1) % 16]); end
        n_cmp++; if ((n_under - u0) + (n_over - o0) + (n_abort - a0) !== 0) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 0", (n_under - u0) + (n_over - o0) + (n_abort - a0)); end
    endtask

    task automatic test_underrun();
        logic [7:0] m;
        int u0;
        u0 = n_under;
        rx_ready = 1'b1;
        select();
        spi_word(8'h00, 8, 1'b1, 1'b0, 1'b0, 8'h00, m);
        rx_ready = 1'b0;
        n_cmp++; if (n_under - u0 !== 1) begin n_fail++; $display("FAIL underrun_count: got %0d want 1", n_under - u0); end
        n_cmp++; if (m !== 8'hFF) begin n_fail++; $display("FAIL underrun_miso: got %h want ff", m); end
        n_cmp++; if (rx_log[(rx_cnt - 1) % 16] !== 8'h00) begin n_fail++; $display("FAIL underrun_rx: got %h want 00", rx_log[(rx_cnt - 1) % 16]); end
    endtask

    task automatic test_overrun();
        logic [7:0] m;
        int o0;
        o0 = n_over;
        rx_ready = 1'b0;
        select();
        spi_word(8'h11, 8, 1'b0, 1'b0, 1'b0, 8'h00, m);
        spi_word(8'h22, 8, 1'b1, 1'b0, 1'b0, 8'h00, m);
        n_cmp++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_rx: got %h/%b want 11/1", rx_data, rx_valid); end
        n_cmp++; if (n_over - o0 !== 1) begin n_fail++; $display("FAIL overrun_count: got %0d want 1", n_over - o0); end
        consume();
        // Ready exactly in the completion cycle of the second word
        o0 = n_over;
        select();
        spi_word(8'h11, 8, 1'b0, 1'b0, 1'b0, 8'h00, m);
        n_cmp++; if (rx_data !== 8'h11) begin n_fail++; $display("FAIL ready_edge_first: got %h want 11", rx_data); end
        spi_word(8'h22, 8, 1'b1, 1'b1, 1'b0, 8'h00, m);
        n_cmp++; if (rx_data !== 8'h22 || rx_valid !== 1'b1) begin n_fail++; $display("FAIL ready_edge_rx: got %h/%b want 22/1", rx_data, rx_valid); end
        n_cmp++; if (n_over - o0 !== 0) begin n_fail++; $display("FAIL ready_edge_overrun: got %0d want 0", n_over - o0); end
        consume();
    endtask

    task automatic test_abort();
        logic [7:0] m;
        int a0;
        a0 = n_abort;
        rx_ready = 1'b0;
        select();
        spi_word(8'hB6, 5, 1'b0, 1'b0, 1'b0, 8'h00, m);
        deselect();
        n_cmp++; if (n_abort - a0 !== 1) begin n_fail++; $display("FAIL abort_count: got %0d want 1", n_abort - a0); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rx_valid: got %b want 0", rx_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        select();
        spi_word(8'h7E, 8, 1'b1, 1'b0, 1'b0, 8'h00, m);
        n_cmp++; if (rx_data !== 8'h7E || rx_valid !== 1'b1) begin n_fail++; $display("FAIL abort_next_rx: got %h/%b want 7e/1", rx_data, rx_valid); end
        n_cmp++; if (n_abort - a0 !== 1) begin n_fail++; $display("FAIL abort_next_count: got %0d want 1", n_abort - a0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] m;
        select();
        spi_word(8'hC0, 3, 1'b0, 1'b0, 1'b0, 8'h00, m);
        RESET_N = 1'b0;
        #1;
        n_cmp++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rx: got %h/%b want 00/0", rx_data, rx_valid); end
        n_cmp++; if (spi_miso !== 1'b1 || spi_miso_oe !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_pins: got miso %b oe %b busy %b want 1 0 0", spi_miso, spi_miso_oe, busy); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_tx_ready: got %b want 1", tx_ready); end
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (12) @(negedge CLOCK_50);
        // SS_n is still low: no frame until it has been seen high
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_no_frame: got %b want 0", busy); end
        deselect();
        select();
        spi_word(8'h81, 8, 1'b1, 1'b0, 1'b0, 8'h00, m);
        n_cmp++; if (rx_data !== 8'h81 || rx_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_next_rx: got %h/%b want 81/1", rx_data, rx_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_underrun();
        test_overrun();
        test_abort();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
